rx_pkt_ctrl: RTL and testbench

//  Packet-level controller for the 8-bit RX FIFO. Accepts decoded bytes framed by SOP/EOP

---
 rtl/rx_pkt_ctrl.sv | 131 +++++++++++++
 tb/tb_rx_pkt_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pkt_ctrl.sv
// rx_pkt_ctrl: packet-level controller for an 8-bit RX FIFO.
// Writes SOP/EOP-framed bytes into the FIFO and counts the packet length.
// It then hands the completed packet to the host one byte per request.
// A framing error, nested SOP, overrun or oversize packet flushes the FIFO.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_sop/rx_data_ready/     decoder framing strobes and byte
//   rx_byte/rx_eop/rx_error
//   fifo_full/fifo_empty/     FIFO status and head byte (first-word-fall-through)
//   fifo_r_data
//   fifo_w_enable/fifo_w_data FIFO write side (combinational)
//   fifo_r_enable             FIFO pop strobe (combinational)
//   host_rd_req               host request for the next byte
//   host_rd_data/host_rd_valid registered read byte, 1-cycle valid pulse
//   pkt_ready                 a complete packet is waiting (state DONE)
//   byte_count                bytes written / bytes still to be read
//   err_flag/overrun          sticky error flags
//   err_clr                   clears the sticky flags (a new error wins)
module rx_pkt_ctrl #(
    parameter int MAX_PKT = 64,
    parameter int CW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_sop,
    input  logic          rx_data_ready,
    input  logic [7:0]    rx_byte,
    input  logic          rx_eop,
    input  logic          rx_error,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    input  logic [7:0]    fifo_r_data,
    output logic          fifo_w_enable,
    output logic [7:0]    fifo_w_data,
    output logic          fifo_r_enable,
    input  logic          host_rd_req,
    output logic [7:0]    host_rd_data,
    output logic          host_rd_valid,
    output logic          pkt_ready,
    output logic [CW-1:0] byte_count,
    output logic          err_flag,
    output logic          overrun,
    input  logic          err_clr
);

    typedef enum logic [1:0] {IDLE, RECV, DONE, FLUSH} state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

    state_t state;
    logic   room;
    logic   rx_abort;
    logic   rx_lost;
    logic   wr_ok;
    logic   host_pop;
    logic   flush_pop;
    logic   err_set;
    logic   ovr_set;

    always_comb begin
        room      = !fifo_full && (byte_count < MAX_CNT);
        // Error and nested SOP take priority over any same-cycle byte.
        rx_abort  = (state == RECV) && (rx_error || rx_sop);
        rx_lost   = (state == RECV) && !rx_abort && rx_data_ready && !room;
        wr_ok     = (state == RECV) && !rx_abort && rx_data_ready && room;
        host_pop  = (state == DONE) && host_rd_req && !fifo_empty && (byte_count != '0);
        flush_pop = (state == FLUSH) && !fifo_empty;
        err_set   = rx_abort || rx_lost;
        // An SOP arriving while a packet waits for the host is dropped but recorded.
        ovr_set   = rx_lost || ((state == DONE) && rx_sop);
    end

    assign fifo_w_enable = wr_ok;
    assign fifo_w_data   = rx_byte;
    assign fifo_r_enable = host_pop || flush_pop;
    assign pkt_ready     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            byte_count    <= '0;
            err_flag      <= 1'b0;
            overrun       <= 1'b0;
            host_rd_valid <= 1'b0;
            host_rd_data  <= 8'h00;
        end else begin
            host_rd_valid <= 1'b0;
            err_flag      <= err_set || (err_flag && !err_clr);
            overrun       <= ovr_set || (overrun && !err_clr);

            case (state)
                IDLE: begin
                    if (rx_sop) begin
                        state      <= RECV;
                        byte_count <= '0;
                    end
                end
                RECV: begin
                    if (rx_abort) begin
                        state <= FLUSH;
                    end else if (rx_data_ready) begin
                        if (room) begin
                            byte_count <= byte_count + CW'(1);
                            if (rx_eop) state <= DONE;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (rx_eop) begin
                        state <= (byte_count == '0) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (byte_count == '0) begin
                        state <= IDLE;
                    end else if (host_pop) begin
                        host_rd_data  <= fifo_r_data;
                        host_rd_valid <= 1'b1;
                        byte_count    <= byte_count - CW'(1);
                    end
                end
                FLUSH: begin
                    byte_count <= '0;
                    if (fifo_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// tb_rx_pkt_ctrl: directed self-checking bench for rx_pkt_ctrl.
// A behavioural first-word-fall-through FIFO model is attached to the DUT.
// fifo_full can be forced to exercise the overrun path.
module tb_rx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_sop = 1'b0;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_eop = 1'b0;
    logic       rx_error = 1'b0;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_w_enable;
    logic [7:0] fifo_w_data;
    logic       fifo_r_enable;
    logic       host_rd_req = 1'b0;
    logic [7:0] host_rd_data;
    logic       host_rd_valid;
    logic       pkt_ready;
    logic [6:0] byte_count;
    logic       err_flag;
    logic       overrun;
    logic       err_clr = 1'b0;

    int tests_run = 0;
    int fails = 0;

    // FIFO model
    logic [7:0] mem [256];
    logic [8:0] wp = '0;
    logic [8:0] rp = '0;
    int         wr_total = 0;
    int         rd_total = 0;
    logic       force_full = 1'b0;

    assign fifo_full   = force_full;
    assign fifo_empty  = (wp == rp);
    assign fifo_r_data = mem[rp[7:0]];

    always @(posedge clk) begin
        if (fifo_w_enable) begin
            mem[wp[7:0]] <= fifo_w_data;
            wp           <= wp + 9'd1;
            wr_total     <= wr_total + 1;
        end
        if (fifo_r_enable && !fifo_empty) begin
            rp       <= rp + 9'd1;
            rd_total <= rd_total + 1;
        end
    end

    always #5 clk = ~clk;

    rx_pkt_ctrl #(.MAX_PKT(64), .CW(7)) dut (
        .clk(clk), .rst(rst),
        .rx_sop(rx_sop), .rx_data_ready(rx_data_ready), .rx_byte(rx_byte),
        .rx_eop(rx_eop), .rx_error(rx_error),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
        .fifo_w_enable(fifo_w_enable), .fifo_w_data(fifo_w_data),
        .fifo_r_enable(fifo_r_enable),
        .host_rd_req(host_rd_req), .host_rd_data(host_rd_data),
        .host_rd_valid(host_rd_valid), .pkt_ready(pkt_ready),
        .byte_count(byte_count), .err_flag(err_flag), .overrun(overrun),
        .err_clr(err_clr)
    );

    // Advance one clock; registered outputs are stable on return.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_sop = 1'b0; rx_data_ready = 1'b0; rx_eop = 1'b0; rx_error = 1'b0;
        host_rd_req = 1'b0; err_clr = 1'b0; force_full = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests_run++; if (byte_count !== 7'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", byte_count); end
        tests_run++; if ({err_flag, overrun, host_rd_valid, pkt_ready} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b exp 0000", {err_flag, overrun, host_rd_valid, pkt_ready}); end
        tests_run++; if (host_rd_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", host_rd_data); end
        tests_run++; if ({fifo_w_enable, fifo_r_enable} !== 2'b00) begin fails++; $display("FAIL reset_strobes got %b exp 00", {fifo_w_enable, fifo_r_enable}); end
    endtask

    task automatic test_basic_packet();
        logic [7:0] pkt [3];
        pkt[0] = 8'hA1; pkt[1] = 8'hB2; pkt[2] = 8'hC3;
        rx_sop = 1'b1; tick(); rx_sop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_data_ready = 1'b1; rx_byte = pkt[i]; rx_eop = (i == 2);
            #1;
            tests_run++; if (fifo_w_enable !== 1'b1) begin fails++; $display("FAIL basic_wen[%0d] got %b exp 1", i, fifo_w_enable); end
            tick();
        end
        idle_inputs();
        #1;
        tests_run++; if (byte_count !== 7'd3) begin fails++; $display("FAIL basic_count got %0d exp 3", byte_count); end
        tests_run++; if (pkt_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got %b exp 1", pkt_ready); end
        tests_run++; if (wr_total !== 3) begin fails++; $display("FAIL basic_writes got %0d exp 3", wr_total); end
        // SOP while a packet waits: overrun only, packet kept
        rx_sop = 1'b1; tick(); rx_sop = 1'b0;
        tests_run++; if ({overrun, err_flag, pkt_ready} !== 3'b101) begin fails++; $display("FAIL done_sop got %b exp 101", {overrun, err_flag, pkt_ready}); end
        tests_run++; if (byte_count !== 7'd3) begin fails++; $display("FAIL done_sop_count got %0d exp 3", byte_count); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tests_run++; if (overrun !== 1'b0) begin fails++; $display("FAIL done_sop_clr got %b exp 0", overrun); end
        for (int i = 0; i < 3; i++) begin
            host_rd_req = 1'b1;
            #1;
            tests_run++; if (fifo_r_enable !== 1'b1) begin fails++; $display("FAIL rd_ren[%0d] got %b exp 1", i, fifo_r_enable); end
            tick();
            host_rd_req = 1'b0;
            tests_run++; if (host_rd_valid !== 1'b1 || host_rd_data !== pkt[i]) begin fails++; $display("FAIL rd_data[%0d] got %b/%h exp 1/%h", i, host_rd_valid, host_rd_data, pkt[i]); end
            tests_run++; if (byte_count !== 7'(2 - i)) begin fails++; $display("FAIL rd_count[%0d] got %0d exp %0d", i, byte_count, 2 - i); end
            tick();
            tests_run++; if (host_rd_valid !== 1'b0) begin fails++; $display("FAIL rd_pulse[%0d] got %b exp 0", i, host_rd_valid); end
        end
        // the idle cycle after the last read moved DONE -> IDLE
        tests_run++; if (pkt_ready !== 1'b0) begin fails++; $display("FAIL basic_to_idle got %b exp 0", pkt_ready); end
        tests_run++; if (err_flag !== 1'b0) begin fails++; $display("FAIL basic_err got %b exp 0", err_flag); end
    endtask

    task automatic test_oversize();
        int w0, r0, n;
        w0 = wr_total; r0 = rd_total;
        rx_sop = 1'b1; tick(); rx_sop = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rx_data_ready = 1'b1; rx_byte = 8'(i);
            tick();
        end
        tests_run++; if (byte_count !== 7'd64) begin fails++; $display("FAIL ovs_count got %0d exp 64", byte_count); end
        rx_byte = 8'hEE;
        #1;
        tests_run++; if (fifo_w_enable !== 1'b0) begin fails++; $display("FAIL ovs_wen65 got %b exp 0", fifo_w_enable); end
        tick();
        idle_inputs();
        tests_run++; if ({overrun, err_flag} !== 2'b11) begin fails++; $display("FAIL ovs_flags got %b exp 11", {overrun, err_flag}); end
        tests_run++; if (wr_total - w0 !== 64) begin fails++; $display("FAIL ovs_writes got %0d exp 64", wr_total - w0); end
        n = 0;
        while (!fifo_empty && n < 200) begin tick(); n++; end
        tests_run++; if (!fifo_empty) begin fails++; $display("FAIL ovs_flush_timeout got nonempty exp empty"); end
        tick();
        tests_run++; if (rd_total - r0 !== 64) begin fails++; $display("FAIL ovs_pops got %0d exp 64", rd_total - r0); end
        tests_run++; if ({pkt_ready, byte_count} !== 8'h00) begin fails++; $display("FAIL ovs_idle got %b/%0d exp 0/0", pkt_ready, byte_count); end
        tests_run++; if (err_flag !== 1'b1) begin fails++; $display("FAIL ovs_sticky got %b exp 1", err_flag); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tests_run++; if ({overrun, err_flag} !== 2'b00) begin fails++; $display("FAIL ovs_clr got %b exp 00", {overrun, err_flag}); end
    endtask

    task automatic test_rx_error();
        int w0, r0, n;
        w0 = wr_total; r0 = rd_total;
        rx_sop = 1'b1; tick(); rx_sop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_data_ready = 1'b1; rx_byte = 8'h10 + 8'(i);
            tick();
        end
        rx_error = 1'b1; rx_byte = 8'h77; host_rd_req = 1'b1;
        #1;
        tests_run++; if (fifo_w_enable !== 1'b0) begin fails++; $display("FAIL err_wen got %b exp 0", fifo_w_enable); end
        tick();
        rx_error = 1'b0; rx_data_ready = 1'b0;
        tests_run++; if ({err_flag, overrun} !== 2'b10) begin fails++; $display("FAIL err_flags got %b exp 10", {err_flag, overrun}); end
        tests_run++; if (wr_total - w0 !== 2) begin fails++; $display("FAIL err_writes got %0d exp 2", wr_total - w0); end
        n = 0;
        while (!fifo_empty && n < 50) begin
            tick(); n++;
            tests_run++; if (host_rd_valid !== 1'b0) begin fails++; $display("FAIL err_rdvalid got %b exp 0", host_rd_valid); end
        end
        tick();
        tests_run++; if (rd_total - r0 !== 2) begin fails++; $display("FAIL err_pops got %0d exp 2", rd_total - r0); end
        tests_run++; if ({host_rd_valid, pkt_ready, err_flag} !== 3'b001) begin fails++; $display("FAIL err_idle got %b exp 001", {host_rd_valid, pkt_ready, err_flag}); end
        idle_inputs();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_fifo_full();
        int w0;
        w0 = wr_total;
        rx_sop = 1'b1; tick(); rx_sop = 1'b0;
        // a clear in the same cycle as a new error must lose
        force_full = 1'b1; rx_data_ready = 1'b1; rx_byte = 8'h55; err_clr = 1'b1;
        #1;
        tests_run++; if (fifo_w_enable !== 1'b0) begin fails++; $display("FAIL full_wen got %b exp 0", fifo_w_enable); end
        tick();
        idle_inputs();
        tests_run++; if ({overrun, err_flag} !== 2'b11) begin fails++; $display("FAIL full_flags got %b exp 11", {overrun, err_flag}); end
        tests_run++; if (fifo_r_enable !== 1'b0 || wr_total !== w0) begin fails++; $display("FAIL full_flush_empty got %b/%0d exp 0/%0d", fifo_r_enable, wr_total, w0); end
        tick();
        tests_run++; if (pkt_ready !== 1'b0) begin fails++; $display("FAIL full_idle got %b exp 0", pkt_ready); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_empty_packet();
        int w0;
        w0 = wr_total;
        rx_data_ready = 1'b1; rx_byte = 8'h99;
        #1;
        tests_run++; if (fifo_w_enable !== 1'b0) begin fails++; $display("FAIL idle_data_wen got %b exp 0", fifo_w_enable); end
        tick();
        rx_sop = 1'b1;
        #1;
        tests_run++; if (fifo_w_enable !== 1'b0) begin fails++; $display("FAIL sop_data_wen got %b exp 0", fifo_w_enable); end
        tick();
        rx_sop = 1'b0; rx_data_ready = 1'b0; rx_eop = 1'b1;
        tick();
        rx_eop = 1'b0;
        tests_run++; if (pkt_ready !== 1'b0 || byte_count !== 7'd0) begin fails++; $display("FAIL empty_pkt got %b/%0d exp 0/0", pkt_ready, byte_count); end
        // back in IDLE: a stray byte is ignored
        rx_data_ready = 1'b1; rx_byte = 8'h5A;
        #1;
        tests_run++; if (fifo_w_enable !== 1'b0) begin fails++; $display("FAIL empty_back_idle got %b exp 0", fifo_w_enable); end
        tick();
        idle_inputs();
        tests_run++; if (wr_total !== w0 || err_flag !== 1'b0) begin fails++; $display("FAIL empty_writes got %0d/%b exp %0d/0", wr_total, err_flag, w0); end
    endtask

    task automatic test_reset_mid_packet();
        rx_sop = 1'b1; tick(); rx_sop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_data_ready = 1'b1; rx_byte = 8'h30 + 8'(i);
            tick();
        end
        idle_inputs();
        tests_run++; if (byte_count !== 7'd5) begin fails++; $display("FAIL mid_count got %0d exp 5", byte_count); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests_run++; if (byte_count !== 7'd0 || host_rd_data !== 8'h00) begin fails++; $display("FAIL mid_rst got %0d/%h exp 0/00", byte_count, host_rd_data); end
        tests_run++; if ({pkt_ready, err_flag, overrun, host_rd_valid} !== 4'b0000) begin fails++; $display("FAIL mid_rst_flags got %b exp 0000", {pkt_ready, err_flag, overrun, host_rd_valid}); end
        // stale bytes remain in the FIFO and IDLE must not pop them
        tests_run++; if (fifo_empty !== 1'b0 || fifo_r_enable !== 1'b0) begin fails++; $display("FAIL mid_fifo got %b/%b exp 0/0", fifo_empty, fifo_r_enable); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_packet();
        test_oversize();
        test_rx_error();
        test_fifo_full();
        test_empty_packet();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
